// File: rtl/fifo_frame_reader_pkg.sv
// fifo_frame_reader_pkg: shared state encoding, length type and header field layout.
// Revision 1.0
`default_nettype none

package fifo_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    STREAM   = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam int DEFAULT_LENGTH_WIDTH = 12;
  typedef logic [DEFAULT_LENGTH_WIDTH-1:0] length_t;

  // Length occupies the low bits of the header word.
  localparam int HDR_LEN_LSB = 0;

  // Skid entry layout: {data, first, last}.
  localparam int SKID_FIRST_BIT = 1;
  localparam int SKID_LAST_BIT  = 0;

endpackage

`default_nettype wire

// File: rtl/fifo_frame_reader_skid_buffer.sv
// skid_buffer: 2-entry register FIFO with push/pop/count; head is always the oldest entry.
// Revision 1.0
`default_nettype none

module skid_buffer #(
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains length-prefixed frames from a non-FWFT FIFO into a framed stream.
// Revision 1.0
`default_nettype none

module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int LENGTH_WIDTH      = DEFAULT_LENGTH_WIDTH,
  parameter int MAX_PAYLOAD_WORDS = 1518
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    fifo_empty,
  output logic                    fifo_read_enable,
  input  logic [DATA_WIDTH-1:0]   fifo_read_data,
  input  logic                    fifo_read_data_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_first,
  output logic                    m_last,
  output logic [LENGTH_WIDTH-1:0] m_length,
  output logic                    frame_done,
  output logic                    length_error
);

  localparam int SKID_WIDTH = DATA_WIDTH + 2;
  localparam logic [LENGTH_WIDTH-1:0] MAX_LEN = LENGTH_WIDTH'(MAX_PAYLOAD_WORDS);
  localparam logic [LENGTH_WIDTH-1:0] ONE     = LENGTH_WIDTH'(1);

  state_t                  state;
  logic                    read_in_flight;
  logic [LENGTH_WIDTH-1:0] reads_left;
  logic [LENGTH_WIDTH-1:0] capture_index;
  logic [LENGTH_WIDTH-1:0] header_length;
  logic [1:0]              skid_count;
  logic [SKID_WIDTH-1:0]   skid_head;
  logic [SKID_WIDTH-1:0]   skid_in;
  logic                    word_arrived;
  logic                    accept;
  logic                    skid_push;
  logic                    credit_ok;
  logic                    header_read;
  logic                    payload_read;
  logic                    drop_read;

  // Valid is only meaningful for the cycle after a read we actually issued.
  assign word_arrived  = read_in_flight && fifo_read_data_valid;
  assign header_length = fifo_read_data[HDR_LEN_LSB +: LENGTH_WIDTH];

  assign m_valid    = (skid_count != 2'd0);
  assign m_data     = skid_head[SKID_WIDTH-1:2];
  assign m_first    = m_valid && skid_head[SKID_FIRST_BIT];
  assign m_last     = m_valid && skid_head[SKID_LAST_BIT];
  assign accept     = m_valid && m_ready;
  assign frame_done = accept && m_last;

  // A beat leaving this cycle frees its slot, which is what keeps one beat per cycle flowing.
  assign credit_ok = (({1'b0, skid_count} - 3'(accept) + 3'(read_in_flight)) < 3'd2);

  assign header_read  = !fifo_empty && ((state == IDLE) || ((state == STREAM) && frame_done));
  assign payload_read = !fifo_empty && (state == STREAM) && (reads_left != '0) && credit_ok;
  assign drop_read    = !fifo_empty && (state == DROP) && (reads_left != '0);

  assign fifo_read_enable = reset_n && (header_read || payload_read || drop_read);

  assign skid_push = (state == STREAM) && word_arrived;
  assign skid_in   = {fifo_read_data, (capture_index == '0), (capture_index == (m_length - ONE))};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      read_in_flight <= 1'b0;
      reads_left     <= '0;
      capture_index  <= '0;
      m_length       <= '0;
      length_error   <= 1'b0;
    end else begin
      read_in_flight <= fifo_read_enable;
      length_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (header_read) state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          if (word_arrived) begin
            capture_index <= '0;
            if (header_length == '0) begin
              length_error <= 1'b1;
              state        <= IDLE;
            end else if (header_length <= MAX_LEN) begin
              m_length   <= header_length;
              reads_left <= header_length;
              state      <= STREAM;
            end else begin
              length_error <= 1'b1;
              reads_left   <= header_length;
              state        <= DROP;
            end
          end
        end
        STREAM: begin
          if (payload_read) reads_left <= reads_left - ONE;
          if (skid_push) capture_index <= capture_index + ONE;
          if (frame_done) state <= header_read ? HDR_WAIT : IDLE;
        end
        DROP: begin
          if (drop_read) reads_left <= reads_left - ONE;
          if (word_arrived && (reads_left == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skid_buffer #(
    .WIDTH(SKID_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (skid_push),
    .push_data(skid_in),
    .pop      (accept),
    .head     (skid_head),
    .count    (skid_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed self-checking bench with a behavioural non-FWFT FIFO.
// Revision 1.0
`default_nettype none

module tb_fifo_frame_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fifo_empty;
  logic        fifo_read_enable;
  logic [15:0] fifo_read_data = '0;
  logic        fifo_read_data_valid = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_first;
  logic        m_last;
  logic [11:0] m_length;
  logic        frame_done;
  logic        length_error;

  fifo_frame_reader dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .fifo_empty          (fifo_empty),
    .fifo_read_enable    (fifo_read_enable),
    .fifo_read_data      (fifo_read_data),
    .fifo_read_data_valid(fifo_read_data_valid),
    .m_data              (m_data),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_first             (m_first),
    .m_last              (m_last),
    .m_length            (m_length),
    .frame_done          (frame_done),
    .length_error        (length_error)
  );

  always #5 clock = ~clock;

  // Behavioural FIFO: data one cycle after a read, valid held high between reads.
  logic [15:0] fifo_mem [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read_enable && !fifo_empty) begin
      fifo_read_data       <= fifo_mem[rd_ptr];
      rd_ptr               <= rd_ptr + 1;
      fifo_read_data_valid <= 1'b1;
    end
  end

  // Monitor of accepted beats, reads and pulses.
  logic [15:0] beat_data  [0:63];
  logic        beat_first [0:63];
  logic        beat_last  [0:63];
  logic [11:0] beat_len   [0:63];
  int          beat_cycle [0:63];
  int          read_cycle [0:4095];
  int          beat_n = 0;
  int          read_count = 0;
  int          spurious = 0;
  int          done_count = 0;
  int          err_count = 0;
  int          cycle = 0;

  always @(posedge clock) begin
    cycle <= cycle + 1;
    if (m_valid && m_ready) begin
      beat_data[beat_n]  <= m_data;
      beat_first[beat_n] <= m_first;
      beat_last[beat_n]  <= m_last;
      beat_len[beat_n]   <= m_length;
      beat_cycle[beat_n] <= cycle;
      beat_n             <= beat_n + 1;
    end
    if (fifo_read_enable) begin
      read_cycle[read_count] <= cycle;
      read_count             <= read_count + 1;
    end
    if (fifo_read_enable && fifo_empty) spurious <= spurious + 1;
    if (frame_done) done_count <= done_count + 1;
    if (length_error) err_count <= err_count + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_beat(input string tag, input int idx, input logic [15:0] d,
                             input logic f, input logic l, input logic [11:0] len);
    check(tag, {beat_data[idx], beat_first[idx], beat_last[idx], beat_len[idx]}, {d, f, l, len});
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int n = 0;
    while (beat_n < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(beat_n >= target), 64'd1);
  endtask

  logic [30:0] snap, prev_snap;
  logic        prev_stalled;
  int          buffered, max_buf, stab_err, credit_err;
  logic        ready_pat [0:3];

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ctrl", {m_valid, m_first, m_last, frame_done, length_error, fifo_read_enable}, 0);
    check("rst_data", {m_data, m_length}, 0);
    reset_n = 1'b1;
    m_ready = 1'b1;

    // 1: single frame of 3
    push(16'd3); push(16'hA001); push(16'hB002); push(16'hC003);
    wait_beats("t1_wait", 3, 40);
    repeat (4) @(negedge clock);
    expect_beat("t1_beat0", 0, 16'hA001, 1'b1, 1'b0, 12'd3);
    expect_beat("t1_beat1", 1, 16'hB002, 1'b0, 1'b0, 12'd3);
    expect_beat("t1_beat2", 2, 16'hC003, 1'b0, 1'b1, 12'd3);
    check("t1_done", done_count, 1);
    check("t1_reads", read_count, 4);

    // 2: back-to-back frames
    push(16'd1); push(16'h1111); push(16'd2); push(16'h2222); push(16'h3333);
    wait_beats("t2_wait", 6, 40);
    repeat (4) @(negedge clock);
    expect_beat("t2_x", 3, 16'h1111, 1'b1, 1'b1, 12'd1);
    expect_beat("t2_y", 4, 16'h2222, 1'b1, 1'b0, 12'd2);
    expect_beat("t2_z", 5, 16'h3333, 1'b0, 1'b1, 12'd2);
    check("t2_reads", read_count, 9);
    check("t2_hdr_early", 64'(read_cycle[6] <= beat_cycle[3]), 64'd1);
    check("t2_done", done_count, 3);

    // 3: backpressure 1,0,0,1
    ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;
    push(16'd4); push(16'hD000); push(16'hD001); push(16'hD002); push(16'hD003);
    max_buf = 0; stab_err = 0; credit_err = 0; prev_stalled = 1'b0; prev_snap = '0;
    for (int c = 0; c < 28; c++) begin
      @(negedge clock);
      m_ready = ready_pat[c % 4];
      #1;
      snap = {m_valid, m_data, m_first, m_last, m_length};
      if (prev_stalled && snap != prev_snap) stab_err++;
      buffered = (read_count - 10) - (beat_n - 6);
      if (buffered > max_buf) max_buf = buffered;
      if (buffered >= 2 && !(m_valid && m_ready) && fifo_read_enable) credit_err++;
      prev_snap = snap;
      prev_stalled = m_valid && !m_ready;
    end
    m_ready = 1'b1;
    wait_beats("t3_wait", 10, 40);
    repeat (4) @(negedge clock);
    check("t3_stable", stab_err, 0);
    check("t3_maxbuf", 64'(max_buf <= 2), 64'd1);
    check("t3_credit", credit_err, 0);
    expect_beat("t3_b0", 6, 16'hD000, 1'b1, 1'b0, 12'd4);
    expect_beat("t3_b1", 7, 16'hD001, 1'b0, 1'b0, 12'd4);
    expect_beat("t3_b2", 8, 16'hD002, 1'b0, 1'b0, 12'd4);
    expect_beat("t3_b3", 9, 16'hD003, 1'b0, 1'b1, 12'd4);
    check("t3_count", beat_n, 10);
    check("t3_reads", read_count, 14);

    // 4: zero length, oversize drop, then a 1-word frame
    push(16'd0);
    push(16'd1519);
    for (int i = 0; i < 1519; i++) push(16'h4000 + 16'(i));
    push(16'd1); push(16'h5A5A);
    wait_beats("t4_wait", 11, 2200);
    repeat (4) @(negedge clock);
    check("t4_lenerr", err_count, 2);
    check("t4_count", beat_n, 11);
    expect_beat("t4_q", 10, 16'h5A5A, 1'b1, 1'b1, 12'd1);
    check("t4_reads", read_count, 1537);
    check("t4_done", done_count, 5);

    // 5: FIFO runs empty mid-frame
    push(16'd3); push(16'hE0A0);
    wait_beats("t5_wait_a", 12, 40);
    repeat (10) @(negedge clock);
    check("t5_stall_beats", beat_n, 12);
    check("t5_stall_reads", read_count, 1539);
    push(16'hE0B0); push(16'hE0C0);
    wait_beats("t5_wait_bc", 14, 40);
    repeat (4) @(negedge clock);
    expect_beat("t5_a", 11, 16'hE0A0, 1'b1, 1'b0, 12'd3);
    expect_beat("t5_b", 12, 16'hE0B0, 1'b0, 1'b0, 12'd3);
    expect_beat("t5_c", 13, 16'hE0C0, 1'b0, 1'b1, 12'd3);
    check("t5_spurious", spurious, 0);

    // 6: reset after two beats of a 5-word frame
    push(16'd5);
    for (int i = 0; i < 5; i++) push(16'hF500 + 16'(i));
    wait_beats("t6_wait_2", 16, 40);
    reset_n = 1'b0;
    flush = 1'b1;
    #1;
    check("t6_rst_ctrl", {m_valid, m_first, m_last, frame_done, length_error, fifo_read_enable}, 0);
    check("t6_rst_data", {m_data, m_length}, 0);
    repeat (2) @(negedge clock);
    flush = 1'b0;
    reset_n = 1'b1;
    push(16'd2); push(16'h6601); push(16'h6602);
    wait_beats("t6_wait_new", 18, 40);
    repeat (4) @(negedge clock);
    expect_beat("t6_e0", 14, 16'hF500, 1'b1, 1'b0, 12'd5);
    expect_beat("t6_e1", 15, 16'hF501, 1'b0, 1'b0, 12'd5);
    expect_beat("t6_f0", 16, 16'h6601, 1'b1, 1'b0, 12'd2);
    expect_beat("t6_f1", 17, 16'h6602, 1'b0, 1'b1, 12'd2);
    check("t6_count", beat_n, 18);
    check("t6_done", done_count, 7);
    check("t6_spurious", spurious, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
